// File: rtl/tone_sequencer_pkg.sv
// tone_seq_pkg: shared note frequency table, half-period helper and envelope
// constants for tone_sequencer. DECAY_DIV is only used when the optional
// TONE_SEQ_ENVELOPE_EN macro is defined.
package tone_seq_pkg;

  // Note code 0 is a rest; every other code selects an entry of NOTE_HZ.
  localparam int unsigned REST            = 0;
  localparam int unsigned NOTE_TABLE_SIZE = 32;

  // Envelope decay prescaler in enabled clocks per level step.
  localparam int unsigned DECAY_DIV = 1 << 16;

  // Equal-tempered notes C4..F#6, rounded to whole Hz (code 10 is A4 = 440 Hz).
  localparam int unsigned NOTE_HZ [NOTE_TABLE_SIZE] = '{
       0,  262,  277,  294,  311,  330,  349,  370,
     392,  415,  440,  466,  494,  523,  554,  587,
     622,  659,  698,  740,  784,  831,  880,  932,
     988, 1047, 1109, 1175, 1245, 1319, 1397, 1480
  };

  // Clocks per half period of a square wave at freq Hz; 0 marks "no tone".
  function automatic int unsigned half_period(input int unsigned clk_freq,
                                              input int unsigned freq);
    return (freq == 0) ? 0 : clk_freq / (2 * freq);
  endfunction

  // Codes beyond the table behave as rests.
  function automatic int unsigned note_hz(input int unsigned code);
    return (code < NOTE_TABLE_SIZE) ? NOTE_HZ[code] : 0;
  endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// tone_sequencer_if: control and audio signals between the pattern/game
// logic (master) and the tone sequencer (slave).
interface tone_sequencer_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned NOTE_W   = 5,
  parameter int unsigned STEP_W   = 5,
  parameter int unsigned TEMPO_W  = 28
);
  logic                         enable;
  logic                         restart;
  logic [TEMPO_W-1:0]           tempo_div;
  logic [STEP_W-1:0]            seq_last;
  logic [CHANNELS*NOTE_W-1:0]   note_codes;
  logic [STEP_W-1:0]            step_index;
  logic                         step_tick;
  logic                         audio_out;
  logic                         audio_en;

  modport master (
    output enable, restart, tempo_div, seq_last, note_codes,
    input  step_index, step_tick, audio_out, audio_en
  );

  modport slave (
    input  enable, restart, tempo_div, seq_last, note_codes,
    output step_index, step_tick, audio_out, audio_en
  );
endinterface

// File: rtl/tone_sequencer_voice.sv
// tone_voice: one square-wave voice. Holds the latched note, the half-period
// counter and the phase bit; with TONE_SEQ_ENVELOPE_EN defined it also keeps
// an 8-bit decaying level that restarts at full on every note load.
module tone_voice
  import tone_seq_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned NOTE_W   = 5,
  parameter int unsigned DIV_W    = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              load_i,
  input  logic [NOTE_W-1:0] note_i,
  output logic              phase_o
`ifdef TONE_SEQ_ENVELOPE_EN
  ,
  output logic [7:0]        level_o
`endif
);

  localparam int unsigned NOTES = 1 << NOTE_W;

  logic [NOTE_W-1:0] note_q;
  logic [DIV_W-1:0]  cnt_q;
  logic              phase_q;
  logic [DIV_W-1:0]  half;
  logic [DIV_W-1:0]  half_tbl [NOTES];

  // Constant half-period ROM, evaluated at elaboration for this clock rate.
  for (genvar i = 0; i < NOTES; i++) begin : g_tbl
    assign half_tbl[i] = DIV_W'(half_period(CLK_FREQ, note_hz(i)));
  end

  assign half    = half_tbl[note_q];
  assign phase_o = phase_q;

  // A changed note restarts the waveform; a repeated note keeps counting
  // through the load so the tone continues without a click.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_q  <= NOTE_W'(REST);
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      if (load_i) begin
        note_q <= note_i;
      end
      if (load_i && (note_i != note_q)) begin
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else if (en_i) begin
        if ((note_q == NOTE_W'(REST)) || (half == '0)) begin
          cnt_q   <= '0;
          phase_q <= 1'b0;
        end else if (cnt_q >= half - DIV_W'(1)) begin
          cnt_q   <= '0;
          phase_q <= ~phase_q;
        end else begin
          cnt_q <= cnt_q + DIV_W'(1);
        end
      end
    end
  end

`ifdef TONE_SEQ_ENVELOPE_EN
  localparam int unsigned PRE_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  logic [7:0]       level_q;
  logic [PRE_W-1:0] pre_q;

  assign level_o = level_q;

  // Level jumps to full on each load, then decays one step per DECAY_DIV
  // enabled clocks and sticks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      pre_q   <= '0;
    end else if (load_i) begin
      level_q <= '1;
      pre_q   <= '0;
    end else if (en_i) begin
      if (pre_q == PRE_W'(DECAY_DIV - 1)) begin
        pre_q <= '0;
        if (level_q != '0) begin
          level_q <= level_q - 8'd1;
        end
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end
    end
  end
`endif

endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: tempo-driven pattern stepper with CHANNELS square-wave
// voices mixed into a wrap-aligned PWM output for the audio jack.
// Optional feature macro: TONE_SEQ_ENVELOPE_EN (per-voice decaying level).
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned NOTE_W   = 5,
  parameter int unsigned STEP_W   = 5,
  parameter int unsigned DIV_W    = 21,
  parameter int unsigned DUTY_W   = 10,
  parameter int unsigned TEMPO_W  = 28
) (
  input  logic             clk,
  input  logic             reset_n,
  tone_sequencer_if.slave  bus
);

  localparam int unsigned LOG2C = $clog2(CHANNELS);
  localparam int unsigned SUM_W = DUTY_W + 1;
  localparam logic [SUM_W-1:0] UNIT     = SUM_W'(1) << (DUTY_W - LOG2C);
  localparam logic [SUM_W-1:0] DUTY_MAX = (SUM_W'(1) << DUTY_W) - SUM_W'(1);

  logic [TEMPO_W-1:0] tempo_cnt_q;
  logic [STEP_W-1:0]  step_q;
  logic               tick_q;
  logic               load_q;
  logic               audio_en_q;
  logic               adv;
  logic [DUTY_W-1:0]  pwm_cnt_q;
  logic [DUTY_W-1:0]  duty_q;
  logic [DUTY_W-1:0]  duty_d;
  logic               phase   [CHANNELS];
  logic [SUM_W-1:0]   contrib [CHANNELS];
  logic [SUM_W-1:0]   sum;

  // >= rather than == so a tempo_div lowered mid-step still advances at once.
  assign adv = bus.enable && (tempo_cnt_q >= bus.tempo_div);

  // Tempo counter, step index and the one-cycle step/load strobes. load_q
  // resets high so the step-0 notes are latched right after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tempo_cnt_q <= '0;
      step_q      <= '0;
      tick_q      <= 1'b0;
      load_q      <= 1'b1;
      audio_en_q  <= 1'b0;
    end else begin
      audio_en_q <= bus.enable;
      if (bus.restart) begin
        tempo_cnt_q <= '0;
        step_q      <= '0;
        tick_q      <= 1'b0;
        load_q      <= 1'b1;
      end else begin
        tick_q <= adv;
        load_q <= adv;
        if (adv) begin
          tempo_cnt_q <= '0;
          step_q      <= (step_q >= bus.seq_last) ? '0 : step_q + STEP_W'(1);
        end else if (bus.enable) begin
          tempo_cnt_q <= tempo_cnt_q + TEMPO_W'(1);
        end
      end
    end
  end

  assign bus.step_index = step_q;
  assign bus.step_tick  = tick_q;
  assign bus.audio_en   = audio_en_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_voice
`ifdef TONE_SEQ_ENVELOPE_EN
    logic [7:0] level;

    tone_voice #(
      .CLK_FREQ (CLK_FREQ),
      .NOTE_W   (NOTE_W),
      .DIV_W    (DIV_W)
    ) u_voice (
      .clk     (clk),
      .rst_n   (reset_n),
      .en_i    (bus.enable),
      .load_i  (load_q),
      .note_i  (bus.note_codes[k*NOTE_W +: NOTE_W]),
      .phase_o (phase[k]),
      .level_o (level)
    );

    // Level 255 maps to just under one full voice unit.
    assign contrib[k] = phase[k] ? SUM_W'((32'(level) * 32'(UNIT)) >> 8) : '0;
`else
    tone_voice #(
      .CLK_FREQ (CLK_FREQ),
      .NOTE_W   (NOTE_W),
      .DIV_W    (DIV_W)
    ) u_voice (
      .clk     (clk),
      .rst_n   (reset_n),
      .en_i    (bus.enable),
      .load_i  (load_q),
      .note_i  (bus.note_codes[k*NOTE_W +: NOTE_W]),
      .phase_o (phase[k])
    );

    assign contrib[k] = phase[k] ? UNIT : '0;
`endif
  end

  // Saturating mix of the voice contributions into the next PWM duty.
  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      sum = sum + contrib[k];
    end
    duty_d = (sum > DUTY_MAX) ? '1 : sum[DUTY_W-1:0];
  end

  // Free-running PWM counter; duty is only taken on wrap so each PWM period
  // is glitch-free. Both hold while paused.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
    end else if (bus.enable) begin
      pwm_cnt_q <= pwm_cnt_q + DUTY_W'(1);
      if (pwm_cnt_q == '1) begin
        duty_q <= duty_d;
      end
    end
  end

  // Gated by the live enable so the pin is silent in every paused cycle;
  // reset clears the counters and so drops the pin asynchronously.
  assign bus.audio_out = bus.enable && (pwm_cnt_q < duty_q);

endmodule
